// File: rtl/y86_pkg.sv
// y86_pkg: shared ALU opcodes and condition-code bit indices for the Y86-64 execute stage
//   ALU_ADD/SUB/AND/XOR : 2-bit ALU control encodings
//   CC_ZF/CC_SF/CC_OF   : bit positions inside the 3-bit condition-code vector
package y86_pkg;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;
    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;
endpackage

// File: rtl/y86_alu_adder.sv
// y86_alu_adder: WIDTH-bit two's complement adder with signed overflow
//   x, y : addends (y is ~b for subtract)
//   cin  : carry in (1 for subtract)
//   sum  : x + y + cin modulo 2^WIDTH, carry-out discarded
//   ovf  : signed overflow of the addition
module y86_alu_adder #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);
    assign sum = x + y + {{(WIDTH-1){1'b0}}, cin};
    // overflow when both addends share a sign that the sum does not
    assign ovf = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
endmodule

// File: rtl/y86_alu.sv
// y86_alu: Y86-64 ALU with registered result/overflow and ZF/SF/OF condition codes
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, control : start an operation, opcode (add/sub/and/xor)
//   a, b              : signed operands
//   set_cc            : with in_valid, load ZF/SF/OF from this result
//   ans, overflow     : registered result and its signed overflow
//   out_valid         : ans/overflow updated on the last edge
//   zf, sf, of        : condition-code register
module y86_alu
    import y86_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [1:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             set_cc,
    output logic [WIDTH-1:0] ans,
    output logic             overflow,
    output logic             out_valid,
    output logic             zf,
    output logic             sf,
    output logic             of
);
    logic             sub;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             res_ovf;
    logic [2:0]       cc;

    // subtract reuses the adder as a + ~b + 1
    assign sub = control == ALU_SUB;

    y86_alu_adder #(.WIDTH(WIDTH)) u_adder (
        .x   (a),
        .y   (sub ? ~b : b),
        .cin (sub),
        .sum (sum),
        .ovf (ovf)
    );

    always_comb begin
        res     = control == ALU_AND ? a & b : control == ALU_XOR ? a ^ b : sum;
        res_ovf = (control == ALU_ADD || control == ALU_SUB) ? ovf : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ans       <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
            cc        <= 3'b0;
            cc[CC_ZF] <= 1'b1;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                ans      <= res;
                overflow <= res_ovf;
            end
            if (in_valid && set_cc) begin
                cc[CC_ZF] <= res == '0;
                cc[CC_SF] <= res[WIDTH-1];
                cc[CC_OF] <= res_ovf;
            end
        end
    end

    assign zf = cc[CC_ZF];
    assign sf = cc[CC_SF];
    assign of = cc[CC_OF];
endmodule

// File: tb/tb_y86_alu.sv
// tb_y86_alu: self-checking bench for y86_alu using an expected-result queue
module tb_y86_alu;
    typedef struct {
        logic [63:0] ans;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  control = 2'b00;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        set_cc = 1'b0;
    logic [63:0] ans;
    logic        overflow;
    logic        out_valid;
    logic        zf, sf, of;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    y86_alu #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .control   (control),
        .a         (a),
        .b         (b),
        .set_cc    (set_cc),
        .ans       (ans),
        .overflow  (overflow),
        .out_valid (out_valid),
        .zf        (zf),
        .sf        (sf),
        .of        (of)
    );

    always #5 clk = ~clk;

    // drive one op, queue its expected result, compare when the DUT presents it
    task automatic issue(input logic [1:0] op, input logic [63:0] xa, input logic [63:0] xb,
                         input logic cc, input logic [63:0] ea, input logic eo, input string name);
        exp_t e;
        @(negedge clk);
        in_valid = 1'b1; control = op; a = xa; b = xb; set_cc = cc;
        e.ans = ea; e.ovf = eo;
        q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0; set_cc = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s out_valid got %b want 1", name, out_valid);
        end else if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (ans !== e.ans || overflow !== e.ovf) begin
                errors++;
                $display("FAIL %s ans/ovf got %0d/%b want %0d/%b", name, $signed(ans), overflow, $signed(e.ans), e.ovf);
            end
        end
    endtask

    task automatic check_cc(input logic ez, input logic es, input logic eo, input string name);
        checks++;
        if ({zf, sf, of} !== {ez, es, eo}) begin
            errors++;
            $display("FAIL %s zf/sf/of got %b%b%b want %b%b%b", name, zf, sf, of, ez, es, eo);
        end
    endtask

    task automatic check_idle(input logic [63:0] held, input string name);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || ans !== held) begin
            errors++;
            $display("FAIL %s out_valid/ans got %b/%0d want 0/%0d", name, out_valid, $signed(ans), $signed(held));
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (ans !== 64'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || {zf, sf, of} !== 3'b100) begin
            errors++;
            $display("FAIL reset got ans=%0d ovf=%b ov=%b cc=%b%b%b want 0 0 0 100", ans, overflow, out_valid, zf, sf, of);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        issue(2'b00, 64'd11, 64'd4, 1'b0, 64'd15, 1'b0, "add 11+4");
        issue(2'b01, 64'd11, 64'd4, 1'b0, 64'd7, 1'b0, "sub 11-4");
        issue(2'b10, 64'd11, 64'd4, 1'b0, 64'd0, 1'b0, "and 11&4");
        issue(2'b11, 64'd11, 64'd4, 1'b0, 64'd15, 1'b0, "xor 11^4");
        check_idle(64'd15, "idle hold");
    endtask

    task automatic test_signed;
        issue(2'b00, -64'sd11, 64'sd4, 1'b0, -64'sd7, 1'b0, "add -11+4");
        issue(2'b01, -64'sd11, 64'sd4, 1'b0, -64'sd15, 1'b0, "sub -11-4");
        issue(2'b10, -64'sd11, 64'sd4, 1'b0, 64'sd4, 1'b0, "and -11&4");
        issue(2'b11, -64'sd11, 64'sd4, 1'b0, -64'sd15, 1'b0, "xor -11^4");
        issue(2'b00, 64'sd11, -64'sd4, 1'b0, 64'sd7, 1'b0, "add 11+-4");
        issue(2'b01, 64'sd11, -64'sd4, 1'b0, 64'sd15, 1'b0, "sub 11--4");
        issue(2'b10, 64'sd11, -64'sd4, 1'b0, 64'sd8, 1'b0, "and 11&-4");
        issue(2'b11, 64'sd11, -64'sd4, 1'b0, -64'sd9, 1'b0, "xor 11^-4");
    endtask

    task automatic test_overflow;
        issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b1, "add max+1");
        issue(2'b01, 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, "sub min-1");
        issue(2'b00, -64'sd1, -64'sd1, 1'b0, -64'sd2, 1'b0, "add -1+-1");
        issue(2'b01, 64'd0, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b1, "sub 0-min");
        issue(2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h8000_0000_0000_0000, 1'b0, "and no ovf");
    endtask

    task automatic test_large;
        issue(2'b00, 64'd56716276, 64'd1, 1'b0, 64'd56716277, 1'b0, "add large");
        issue(2'b01, 64'd8762547857, -64'sd1, 1'b0, 64'd8762547858, 1'b0, "sub large");
    endtask

    // random ops against a 66-bit signed reference; the final op leaves its flags in CC
    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            logic [1:0] op;
            logic [63:0] xa, xb, ea;
            logic signed [65:0] wa, wb, r;
            logic eo;
            op = 2'($urandom_range(0, 3));
            xa = {$urandom, $urandom};
            xb = {$urandom, $urandom};
            if (i % 4 == 0) xb = xa;
            wa = 66'(signed'(xa));
            wb = 66'(signed'(xb));
            r = op == 2'b00 ? wa + wb : wa - wb;
            ea = op == 2'b10 ? (xa & xb) : op == 2'b11 ? (xa ^ xb) : r[63:0];
            eo = op[1] ? 1'b0 : (r > 66'sh0_7FFF_FFFF_FFFF_FFFF || r < -66'sh0_8000_0000_0000_0000);
            issue(op, xa, xb, 1'b1, ea, eo, "random");
            check_cc(ea == 64'd0, ea[63], eo, "random cc");
        end
    endtask

    task automatic test_cc;
        issue(2'b00, 64'd1, 64'd1, 1'b1, 64'd2, 1'b0, "cc prep add");
        check_cc(1'b0, 1'b0, 1'b0, "cc prep");
        issue(2'b01, 64'd5, 64'd5, 1'b1, 64'd0, 1'b0, "cc sub 5-5");
        check_cc(1'b1, 1'b0, 1'b0, "cc zero");
        issue(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0, 64'h8000_0000_0000_0000, 1'b0, "cc and nocc");
        check_cc(1'b1, 1'b0, 1'b0, "cc hold");
        issue(2'b01, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "cc sub 0-1");
        check_cc(1'b0, 1'b1, 1'b0, "cc neg");
        issue(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1, 64'h8000_0000_0000_0000, 1'b1, "cc add ovf");
        check_cc(1'b0, 1'b1, 1'b1, "cc ovf");
        @(negedge clk);
        set_cc = 1'b1; in_valid = 1'b0; a = 64'd0; b = 64'd0; control = 2'b00;
        @(posedge clk);
        #1;
        set_cc = 1'b0;
        check_cc(1'b0, 1'b1, 1'b1, "cc no valid");
    endtask

    task automatic test_back_to_back_reset;
        issue(2'b00, 64'd40, 64'd2, 1'b1, 64'd42, 1'b0, "pre reset op");
        @(negedge clk);
        in_valid = 1'b1; control = 2'b00; a = 64'd7; b = 64'd8; set_cc = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ans !== 64'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || {zf, sf, of} !== 3'b100) begin
            errors++;
            $display("FAIL async reset got ans=%0d ovf=%b ov=%b cc=%b%b%b want 0 0 0 100", ans, overflow, out_valid, zf, sf, of);
        end
        @(posedge clk);
        #1;
        checks++;
        if (ans !== 64'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset held got ans=%0d ov=%b want 0 0", ans, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0; set_cc = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (ans !== 64'd0 || overflow !== 1'b0 || out_valid !== 1'b0 || {zf, sf, of} !== 3'b100) begin
            errors++;
            $display("FAIL post reset got ans=%0d ovf=%b ov=%b cc=%b%b%b want 0 0 0 100", ans, overflow, out_valid, zf, sf, of);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_overflow;
        test_large;
        test_random;
        test_cc;
        test_back_to_back_reset;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover got %0d want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
